serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` one bit per clock, LSB first. It uses a single 1-bit full-subtractor cell and a borrow flip-flop. It is the sequential counterpart of the team's combinational full adder and performs the inverse operation. It sits behind a simple start/done handshake, so any control FSM in the datapath can issue a subtraction and collect the difference and final borrow.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  request a subtraction; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  output  1  high while the bit-serial operation is in progress (SHIFT state).
- `done`  output  1  one-cycle pulse marking a new valid result.
- `diff`  output  WIDTH  result register: `(a - b) mod 2^WIDTH`.
- `borrow`  output  1  final borrow out; 1 iff `a < b` (unsigned).

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE & `start` → SHIFT.
  - SHIFT & `count == WIDTH-1` → DONE.
  - DONE → IDLE unconditionally.
- Accept (IDLE & `start`):
  - Load shift registers `sa <= a`, `sb <= b`.
  - Clear the working borrow `bw <= 0`, clear `count <= 0`, clear the working difference `sd <= 0`.
- Each SHIFT edge:
  - Compute `d = sa[0] ^ sb[0] ^ bw`.
  - Compute `bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw)`.
  - Update `sd <= {d, sd[WIDTH-1:1]}`, `sa <= sa >> 1`, `sb <= sb >> 1`, `bw <= bo`, `count <= count + 1`.
- On the edge entering DONE, copy `diff <= {d, sd[WIDTH-1:1]}` (the final bit included) and `borrow <= bo`.
- `diff` and `borrow` hold the previous result throughout a new operation. They change only on DONE entry.
- `start` is ignored in SHIFT and DONE; it is not queued.
- `a` and `b` may change freely after the accepting edge.
- Reset mid-operation aborts the operation:
  - State returns to IDLE; all registers and outputs clear to 0.
  - No `done` pulse is produced for the aborted operation.

## Timing
- Reset values: `busy = 0`, `done = 0`, `diff = 0`, `borrow = 0`, state IDLE, `count = 0`.
- `start` accepted at edge k:
  - `busy` is high from edge k to edge k+WIDTH (exactly WIDTH cycles).
  - `done` and the new `diff`/`borrow` appear at edge k+WIDTH.
  - `done` is high for exactly one cycle and drops at edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge k+WIDTH+2, when `start` is sampled in IDLE after DONE.
- `busy` and `done` are never high together.
- All outputs are registered (`busy`/`done` decoded from registered state only); there is no combinational input-to-output path.
- `count` width is `$clog2(WIDTH)`. It wraps to 0 on each accept and never wraps within an operation.

## Structure
- Shared package `serial_arith_pkg`:
  - State encoding constants `ST_IDLE = 2'd0`, `ST_SHIFT = 2'd1`, `ST_DONE = 2'd2`.
  - Default width constant `SA_DEFAULT_WIDTH = 8`.
- Sub-module `full_subtractor`: purely combinational 1-bit cell.
  - Ports: `a`, `b`, `bin` in; `d`, `bout` out.
  - Instantiated once with ordered port mapping.
- Top level holds the FSM, shift registers, borrow flop, counter and result registers.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Basic: `a=200`, `b=55`, pulse `start` → `busy` high 8 cycles, then `done` pulse with `diff=145`, `borrow=0`.
- Underflow: `a=5`, `b=10` → `diff=251`, `borrow=1`; `diff` keeps its previous value (145) until the `done` edge.
- Boundaries:
  - `a=0`, `b=0` → `0/0`.
  - `a=255`, `b=255` → `0/0`.
  - `a=0`, `b=255` → `diff=1`, `borrow=1`.
  - `a=255`, `b=0` → `diff=255`, `borrow=0`.
- Handshake:
  - Hold `start` high continuously → operations complete every 10 cycles, with `done` pulses spaced 10 cycles apart.
  - Pulse `start` during SHIFT with different operands → ignored; the result matches the first operands.
- Reset mid-op: assert `rst` on the 4th SHIFT cycle with `a=100`, `b=1` → all outputs 0 immediately (asynchronous), no `done`. A following `a=100`, `b=1` op then yields `diff=99`, `borrow=0`.
- Exhaustive, WIDTH=3: all 64 `(a,b)` pairs issued back-to-back → each `done` gives `diff == (a-b) & 7` and `borrow == (a<b)`.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared constants for the bit-serial arithmetic blocks
// Contents: FSM state encodings (IDLE/SHIFT/DONE) and the default operand width.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full-subtractor cell
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in) -> d (difference bit), bout (borrow out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor (a - b), LSB first, start/done handshake
// Ports: clk, rst (async active-high), start, a, b in; busy (SHIFT in progress), done (1-cycle result pulse),
//        diff ((a-b) mod 2^WIDTH), borrow (1 iff a < b) out. All outputs registered.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic d_bit;
    logic bo_bit;

    full_subtractor u_fs (sa_q[0], sb_q[0], bw_q, d_bit, bo_bit);

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        bw_d     = bw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    sa_d    = a;
                    sb_d    = b;
                    sd_d    = '0;
                    bw_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                sd_d  = {d_bit, sd_q[WIDTH-1:1]};
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                bw_d  = bo_bit;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    // Publish including the bit computed on this same edge.
                    diff_d   = {d_bit, sd_q[WIDTH-1:1]};
                    borrow_d = bo_bit;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            bw_q     <= bw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT);
    assign done   = (state_q == ST_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard testbench for serial_subtractor (WIDTH=8 directed, WIDTH=3 exhaustive)
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;
    logic       start3;
    logic [2:0] a3, b3;
    logic       busy3, done3, borrow3;
    logic [2:0] diff3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] q8[$];
    logic [3:0] q3[$];
    time        done_times[$];

    logic [7:0] last_diff;
    logic       last_borrow;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow(borrow3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitors: pop the oldest expected result whenever a done pulse is presented.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            done_times.push_back($time);
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 1, 0);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("w8_diff", diff8, e[7:0]);
                chk("w8_borrow", borrow8, e[8]);
            end
        end
    end

    always @(negedge clk) begin
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("w3_unexpected_done", 1, 0);
            end else begin
                logic [3:0] e;
                e = q3.pop_front();
                chk("w3_diff", diff3, e[2:0]);
                chk("w3_borrow", borrow3, e[3]);
            end
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [7:0] ed, input logic eb);
        @(negedge clk);
        a8 = ta; b8 = tb_v; start8 = 1'b1;
        q8.push_back({eb, ed});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start8 = 1'b0;
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end
            chk("busy_high", busy8, 1);
            chk("no_done_while_busy", done8, 0);
            chk("diff_hold", diff8, last_diff);
            chk("borrow_hold", borrow8, last_borrow);
        end
        @(negedge clk);
        chk("busy_low_at_done", busy8, 0);
        chk("done_high", done8, 1);
        @(negedge clk);
        chk("done_one_cycle", done8, 0);
        last_diff = ed;
        last_borrow = eb;
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start3 = 1'b0; a3 = '0; b3 = '0;
        last_diff = '0; last_borrow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_diff", diff8, 0);
        chk("rst_borrow", borrow8, 0);
        rst = 1'b0;

        run_op(8'd200, 8'd55, 8'd145, 1'b0);
        run_op(8'd5,   8'd10, 8'd251, 1'b1);
        run_op(8'd0,   8'd0,  8'd0,   1'b0);
        run_op(8'd255, 8'd255, 8'd0,  1'b0);
        run_op(8'd0,   8'd255, 8'd1,  1'b1);
        run_op(8'd255, 8'd0,  8'd255, 1'b0);

        // start held high: three accepts 10 cycles apart, then released before a fourth.
        done_times.delete();
        @(negedge clk);
        a8 = 8'd77; b8 = 8'd33; start8 = 1'b1;
        repeat (3) q8.push_back({1'b0, 8'd44});
        repeat (30) @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        chk("cont_done_count", done_times.size(), 3);
        if (done_times.size() == 3) begin
            chk("cont_spacing_1", 32'(done_times[1] - done_times[0]), 100);
            chk("cont_spacing_2", 32'(done_times[2] - done_times[1]), 100);
        end
        last_diff = 8'd44; last_borrow = 1'b0;

        // start pulsed during SHIFT with other operands must be ignored.
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
        q8.push_back({1'b0, 8'd6});
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("ignored_start_queue_empty", q8.size(), 0);
        chk("ignored_start_idle", busy8, 0);
        last_diff = 8'd6; last_borrow = 1'b0;

        // Asynchronous reset during the 4th SHIFT cycle.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
        q8.push_back({1'b0, 8'd99});
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        void'(q8.pop_back());
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_diff", diff8, 0);
        chk("abort_borrow", borrow8, 0);
        @(negedge clk);
        rst = 1'b0;
        last_diff = '0; last_borrow = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_idle", busy8, 0);
        run_op(8'd100, 8'd1, 8'd99, 1'b0);

        // WIDTH=3 exhaustive, one accept every WIDTH+2 cycles.
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                logic [2:0] xa, xb, xd;
                xa = 3'(ia); xb = 3'(ib);
                xd = xa - xb;
                @(negedge clk);
                a3 = xa; b3 = xb; start3 = 1'b1;
                q3.push_back({(ia < ib) ? 1'b1 : 1'b0, xd});
                @(negedge clk);
                start3 = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        repeat (8) @(negedge clk);
        chk("w8_queue_drained", q8.size(), 0);
        chk("w3_queue_drained", q3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
